// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Async-FIFO read-side adapter. Issues reads against rempty,
//                absorbs the one-cycle memory latency in a 3-entry skid buffer
//                and presents the words as a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             r_en,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       buf_cnt
);

  localparam logic [1:0] c_LAST_PTR = 2'd2;
  localparam logic [2:0] c_DEPTH    = 3'd3;

  logic [DSIZE-1:0] buf_q [3];
  logic [DSIZE-1:0] buf_d [3];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic             inflight_q, inflight_d;

  logic [2:0]       w_occupancy;
  logic             w_rd_fire;
  logic             w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == c_LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are gated only by registered state, so m_ready never reaches r_en.
  assign w_occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
  assign r_en        = ~rrst & ~rempty & (w_occupancy < c_DEPTH);
  assign w_rd_fire   = r_en & ~rempty;

  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign w_pop   = m_valid & m_ready;
  assign buf_cnt = buf_cnt_q;

  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = w_rd_fire;
    buf_cnt_d  = buf_cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};

    if (inflight_q) begin
      buf_d[wr_ptr_q] = rdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset: it is only observed while buf_cnt is non-zero.
  always_ff @(posedge rclk) begin
    buf_q <= buf_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Self-checking bench for fifo_rd_stream with a queue-based
//                FIFO model and an in-order output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             r_en;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
  logic [1:0]       buf_cnt;

  fifo_rd_stream #(.DSIZE(DSIZE)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .r_en    (r_en),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .buf_cnt (buf_cnt)
  );

  always #5 rclk = ~rclk;

  logic [7:0] mem_q [$];
  logic [7:0] exp_q [$];
  logic       gate;
  int         total = 0;
  int         bad   = 0;
  int         fires = 0;
  int         delivered = 0;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       exp_ren;
    logic       exp_mv;
    logic [1:0] exp_cnt;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load(input logic [7:0] w);
    mem_q.push_back(w);
    exp_q.push_back(w);
    rempty = gate || (mem_q.size() == 0);
  endtask

  // One read-clock cycle: sample handshakes mid-cycle, then update the
  // FIFO model just after the edge so rdata carries the word read.
  task automatic tick();
    logic fire;
    logic [7:0] e;
    @(negedge rclk);
    fire = r_en & ~rempty;
    if (m_valid && m_ready) begin
      delivered++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("stream_order", {24'd0, m_data}, {24'd0, e});
      end
    end
    @(posedge rclk);
    #1;
    if (fire) begin
      fires++;
      if (mem_q.size() == 0) check("read_from_empty", 32'd1, 32'd0);
      else rdata = mem_q.pop_front();
    end
    rempty = gate || (mem_q.size() == 0);
    #1;
  endtask

  initial begin
    int first_v, last_v, nvalid, max_cnt, fires0, cyc;

    rrst = 1'b1; rempty = 1'b1; rdata = '0; m_ready = 1'b0; gate = 1'b0;
    tick(); tick();

    // Reset release then backpressure: FIFO holds 0x10..0x17.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h10};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'h10};
    for (int i = 6; i < 12; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 8'h10};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 8'h10};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 8'h11};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h12};
    vt[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h13};
    vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h14};
    vt[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h15};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 8'h16};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 8'h17};
    vt[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i));
    fires0 = fires;
    for (int i = 0; i < 21; i++) begin
      rrst    = vt[i].rst;
      m_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_r_en", i), {31'd0, r_en}, {31'd0, vt[i].exp_ren});
      check($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vt[i].exp_mv});
      check($sformatf("vec%0d_buf_cnt", i), {30'd0, buf_cnt}, {30'd0, vt[i].exp_cnt});
      if (vt[i].chk_data)
        check($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vt[i].exp_data});
      if (i == 11) check("throttle_fires", fires - fires0, 32'd3);
      tick();
    end

    // Single word: m_valid two cycles after r_en, for exactly one cycle.
    m_ready = 1'b1;
    load(8'hA5);
    #1;
    check("single_r_en_c0", {31'd0, r_en}, 32'd1);
    check("single_mv_c0", {31'd0, m_valid}, 32'd0);
    tick();
    check("single_mv_c1", {31'd0, m_valid}, 32'd0);
    tick();
    check("single_mv_c2", {31'd0, m_valid}, 32'd1);
    check("single_data", {24'd0, m_data}, 32'hA5);
    tick();
    check("single_mv_after", {31'd0, m_valid}, 32'd0);
    check("single_cnt_after", {30'd0, buf_cnt}, 32'd0);

    // Streaming 0x00..0x0F with m_ready held high.
    for (int i = 0; i < 16; i++) load(8'(i));
    #1;
    first_v = -1; last_v = -1; nvalid = 0; max_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (int'(buf_cnt) > max_cnt) max_cnt = int'(buf_cnt);
      tick();
    end
    check("stream_valid_cycles", nvalid, 32'd16);
    check("stream_no_gaps", last_v - first_v + 1, 32'd16);
    check("stream_max_cnt", max_cnt, 32'd1);
    check("stream_drained", exp_q.size(), 32'd0);

    // Random ready and empty gating, 1000 words.
    fires0 = fires; delivered = 0;
    for (int i = 0; i < 1000; i++) load(8'(i * 7 + 3));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20000) begin
      m_ready = 1'($urandom_range(0, 1));
      gate    = ($urandom_range(0, 3) == 0);
      rempty  = gate || (mem_q.size() == 0);
      #1;
      tick();
      cyc++;
    end
    gate = 1'b0; m_ready = 1'b1;
    rempty = (mem_q.size() == 0);
    tick(); tick();
    check("random_all_delivered", exp_q.size(), 32'd0);
    check("random_count", delivered, 32'd1000);
    check("random_reads", fires - fires0, 32'd1000);

    // Mid-stream reset with buf_cnt=2 and a word in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
    #1;
    tick(); tick(); tick();
    check("mid_cnt_before", {30'd0, buf_cnt}, 32'd2);
    check("mid_r_en_full", {31'd0, r_en}, 32'd0);
    rrst = 1'b1;
    #1;
    check("mid_r_en_in_reset", {31'd0, r_en}, 32'd0);
    tick();
    mem_q.delete(); exp_q.delete();
    rempty = 1'b1;
    #1;
    check("mid_mv_after_rst", {31'd0, m_valid}, 32'd0);
    check("mid_cnt_after_rst", {30'd0, buf_cnt}, 32'd0);
    rrst = 1'b0; m_ready = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (m_valid) nvalid++;
    end
    check("mid_no_stale_word", nvalid, 32'd0);
    load(8'h5A);
    #1;
    tick(); tick();
    check("mid_recover_mv", {31'd0, m_valid}, 32'd1);
    check("mid_recover_data", {24'd0, m_data}, 32'h5A);
    tick();
    check("mid_recover_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
